// File: rtl/stopwatch_timer_core_if.sv
// Control and status bundle between the stopwatch core and its host logic
// (front-panel controls, 7-segment driver, alarm/LED logic).
interface stopwatch_timer_core_if #(
    parameter int unsigned MIN_W = 7
);
    logic             clear;
    logic             run;
    logic             dir;
    logic             load;
    logic [MIN_W-1:0] load_min;
    logic [5:0]       load_sec;
    logic             lap;
    logic [MIN_W-1:0] minutes;
    logic [5:0]       seconds;
    logic [MIN_W-1:0] lap_minutes;
    logic [5:0]       lap_seconds;
    logic             lap_valid;
    logic             tick;
    logic             done;
    logic             overflow;

    modport master (
        output clear, run, dir, load, load_min, load_sec, lap,
        input  minutes, seconds, lap_minutes, lap_seconds, lap_valid, tick, done, overflow
    );

    modport slave (
        input  clear, run, dir, load, load_min, load_sec, lap,
        output minutes, seconds, lap_minutes, lap_seconds, lap_valid, tick, done, overflow
    );
endinterface

// File: rtl/stopwatch_timer_core.sv
// mm:ss up/down time-keeping core with prescaler, preload, pause, lap capture
// and wrap/saturate at full scale.
module stopwatch_timer_core #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned MIN_W   = 7,
    parameter int unsigned MAX_MIN = 99,
    parameter int unsigned WRAP    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    stopwatch_timer_core_if.slave bus
);
    localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned PS_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0]  PS_MAX    = PS_W'(DIV - 1);
    localparam logic [MIN_W-1:0] MAX_MIN_C = MIN_W'(MAX_MIN);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_e;

    state_e           state_q;
    logic [PS_W-1:0]  ps_q;
    logic [MIN_W-1:0] min_q, lap_min_q;
    logic [5:0]       sec_q, lap_sec_q;
    logic             lap_valid_q, tick_q, done_q, overflow_q;

    logic [MIN_W-1:0] min_d, ld_min_s;
    logic [5:0]       sec_d, ld_sec_s;
    logic             at_end_s, full_s, changes_s, zero_s;

    // Time value one tick ahead in the sampled direction, plus end-of-range flags.
    always_comb begin
        min_d    = min_q;
        sec_d    = sec_q;
        at_end_s = 1'b0;
        full_s   = 1'b0;
        if (bus.dir == 1'b0) begin
            if (sec_q == 6'd59) begin
                if (min_q == MAX_MIN_C) begin
                    full_s = 1'b1;
                    if (WRAP != 0) begin
                        min_d = '0;
                        sec_d = 6'd0;
                    end else begin
                        at_end_s = 1'b1;
                    end
                end else begin
                    min_d = min_q + MIN_W'(1);
                    sec_d = 6'd0;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else begin
            if (sec_q == 6'd0) begin
                if (min_q == '0) begin
                    at_end_s = 1'b1;
                end else begin
                    min_d = min_q - MIN_W'(1);
                    sec_d = 6'd59;
                end
            end else begin
                sec_d = sec_q - 6'd1;
                if ((min_q == '0) && (sec_q == 6'd1)) begin
                    at_end_s = 1'b1;
                end else begin
                    at_end_s = 1'b0;
                end
            end
        end
        changes_s = (min_d != min_q) || (sec_d != sec_q);
        zero_s    = (min_q == '0) && (sec_q == 6'd0);
        ld_min_s  = (bus.load_min > MAX_MIN_C) ? MAX_MIN_C : bus.load_min;
        ld_sec_s  = (bus.load_sec > 6'd59) ? 6'd59 : bus.load_sec;
    end

    // Control FSM, prescaler, time/lap registers and pulse outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ps_q        <= '0;
            min_q       <= '0;
            sec_q       <= 6'd0;
            lap_min_q   <= '0;
            lap_sec_q   <= 6'd0;
            lap_valid_q <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            if (bus.clear) begin
                state_q     <= ST_IDLE;
                ps_q        <= '0;
                min_q       <= '0;
                sec_q       <= 6'd0;
                lap_min_q   <= '0;
                lap_sec_q   <= 6'd0;
                lap_valid_q <= 1'b0;
                overflow_q  <= 1'b0;
            end else if (bus.load) begin
                state_q <= ST_IDLE;
                ps_q    <= '0;
                min_q   <= ld_min_s;
                sec_q   <= ld_sec_s;
            end else begin
                // Lap samples the pre-tick value even when a tick lands on this edge.
                if (bus.lap) begin
                    lap_min_q   <= min_q;
                    lap_sec_q   <= sec_q;
                    lap_valid_q <= 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (bus.run && bus.dir && zero_s) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (bus.run) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (!bus.run) begin
                            state_q <= ST_PAUSE;
                        end else if (ps_q == PS_MAX) begin
                            ps_q   <= '0;
                            min_q  <= min_d;
                            sec_q  <= sec_d;
                            tick_q <= changes_s;
                            if (full_s) begin
                                overflow_q <= 1'b1;
                            end
                            if (at_end_s) begin
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        end else begin
                            ps_q <= ps_q + PS_W'(1);
                        end
                    end
                    ST_PAUSE: begin
                        state_q <= bus.run ? ST_RUN : ST_PAUSE;
                    end
                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.minutes     = min_q;
    assign bus.seconds     = sec_q;
    assign bus.lap_minutes = lap_min_q;
    assign bus.lap_seconds = lap_sec_q;
    assign bus.lap_valid   = lap_valid_q;
    assign bus.tick        = tick_q;
    assign bus.done        = done_q;
    assign bus.overflow    = overflow_q;
endmodule
